// File: rtl/serial_link_pkg.sv
// serial_link_pkg
//   Definitions shared by the serial frame transmitter and the matching
//   receiver: the frame state encoding, the line levels for each part of a
//   frame, and a helper that returns the length of one frame in clock cycles.
package serial_link_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // Line time of one frame: start bit, data_w data bits, stop bit.
    function automatic int frame_len(input int data_w, input int clk_div);
        return (data_w + 2) * clk_div;
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// serial_bit_timer
//   Counts clock cycles within one serial bit period and flags the last one.
//   Shared by the transmitter and receiver.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset (counter -> 0)
//   clear    in   force the counter to 0 on the next edge
//   bit_done out  high in the last cycle (count CLK_DIV-1) of a bit period
module serial_bit_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_done
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // Wrapping on bit_done lets consecutive bits of the same state run back
    // to back; a state change always coincides with bit_done, so every state
    // is entered with the counter at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear || bit_done) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // With CLK_DIV=1 the counter never leaves 0, so this is constant 1.
    assign bit_done = (r_cnt == TERM_CNT);

endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx
//   Parallel-to-serial frame transmitter. A word accepted over valid/ready is
//   sent as start bit (0), DATA_W data bits LSB first, stop bit (1), each bit
//   held for CLK_DIV cycles. The line idles high.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset; aborts any frame in flight
//   data_in    in   word to send, sampled only on the accepting edge
//   valid_in   in   data_in holds a word to send
//   ready_out  out  high only in IDLE; accept = valid_in & ready_out
//   tx_out     out  registered serial line
//   busy       out  a frame is in progress
module serial_frame_tx
    import serial_link_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              tx_out,
    output logic              busy
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    state_t            r_state;
    logic [DATA_W-1:0] r_shreg;
    logic [IDX_W-1:0]  r_idx;
    logic              r_tx;

    logic              w_bit_done;
    logic              w_accept;
    logic [DATA_W-1:0] w_shifted;

    assign ready_out = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign tx_out    = r_tx;
    assign w_accept  = valid_in && ready_out;

    // Right shift with a 1 filled in at the top; written this way so that it
    // stays legal for DATA_W=1.
    assign w_shifted = DATA_W'({1'b1, r_shreg} >> 1);

    // Held clear while idle so the start bit begins a fresh bit period.
    serial_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (r_state == IDLE),
        .bit_done (w_bit_done)
    );

    // The line level is registered alongside the state, so every transition
    // loads the level of the bit that the next state drives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_idx   <= '0;
            r_tx    <= IDLE_LEVEL;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shreg <= data_in;
                        r_state <= START;
                        r_tx    <= START_LEVEL;
                    end
                end
                START: begin
                    if (w_bit_done) begin
                        r_idx   <= '0;
                        r_state <= DATA;
                        r_tx    <= r_shreg[0];
                    end
                end
                DATA: begin
                    if (w_bit_done) begin
                        r_shreg <= w_shifted;
                        r_idx   <= r_idx + 1'b1;
                        if (r_idx == LAST_IDX) begin
                            r_state <= STOP;
                            r_tx    <= STOP_LEVEL;
                        end else begin
                            r_tx    <= w_shifted[0];
                        end
                    end
                end
                STOP: begin
                    if (w_bit_done) begin
                        r_state <= IDLE;
                        r_tx    <= IDLE_LEVEL;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx
//   Directed bench for serial_frame_tx: a default instance (DATA_W=8,
//   CLK_DIV=4) and a corner instance (DATA_W=1, CLK_DIV=1). Expected line
//   levels are queued per cycle when a word is accepted and popped as the
//   line is sampled on falling edges.
module tb_serial_frame_tx;
    import serial_link_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out, tx_out, busy;

    logic [0:0] c_data;
    logic       c_valid;
    logic       c_ready, c_tx, c_busy;

    int compared = 0;
    int mism     = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    serial_frame_tx #(.DATA_W(8), .CLK_DIV(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .tx_out    (tx_out),
        .busy      (busy)
    );

    serial_frame_tx #(.DATA_W(1), .CLK_DIV(1)) u_corner (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (c_data),
        .valid_in  (c_valid),
        .ready_out (c_ready),
        .tx_out    (c_tx),
        .busy      (c_busy)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input bit corner, input string tag);
        chk({tag, "_tx"},    corner ? c_tx    : tx_out,    1'b1);
        chk({tag, "_ready"}, corner ? c_ready : ready_out, 1'b1);
        chk({tag, "_busy"},  corner ? c_busy  : busy,      1'b0);
    endtask

    task automatic push_frame(input int dw, input int div, input logic [7:0] w);
        logic [7:0] wv;
        wv = w;
        for (int i = 0; i < div; i++) exp_q.push_back(1'b0);
        for (int b = 0; b < dw; b++)
            for (int i = 0; i < div; i++) exp_q.push_back(wv[b]);
        for (int i = 0; i < div; i++) exp_q.push_back(1'b1);
    endtask

    // Called just after a falling edge; returns just after the accepting edge
    // with the expected frame queued.
    task automatic send(input bit corner, input logic [7:0] w);
        int n;
        n = 0;
        if (corner) begin c_data = w[0]; c_valid = 1'b1; end
        else        begin data_in = w;   valid_in = 1'b1; end
        while ((corner ? c_ready : ready_out) !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", n < 100, 1'b1);
        @(posedge clk);
        if (corner) push_frame(1, 1, w);
        else        push_frame(8, 4, w);
    endtask

    // mode 0: leave inputs alone; 1: data_in=FF and toggle valid_in each
    // cycle; 2: data_in=80 with valid held; 3: drop valid after acceptance.
    task automatic check_frame(input bit corner, input int n, input int mode,
                               input string tag);
        logic e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                chk({tag, "_queue_empty"}, 1'b1, 1'b0);
                return;
            end
            e = exp_q.pop_front();
            chk({tag, "_tx"},   corner ? c_tx   : tx_out, e);
            chk({tag, "_busy"}, corner ? c_busy : busy,   1'b1);
            case (mode)
                1: begin data_in = 8'hFF; valid_in = ~valid_in; end
                2: data_in = 8'h80;
                3: begin valid_in = 1'b0; c_valid = 1'b0; end
                default: ;
            endcase
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        data_in  = 8'h00;
        valid_in = 1'b0;
        c_data   = 1'b0;
        c_valid  = 1'b0;

        // Reset and idle
        repeat (3) begin
            @(negedge clk);
            chk_idle(0, "in_reset");
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk_idle(0, "idle");
        end

        // Single frame 0xA5
        send(0, 8'hA5);
        check_frame(0, frame_len(8, 4), 3, "a5");
        @(negedge clk);
        chk_idle(0, "a5_after");
        chk("a5_queue_drained", exp_q.size() == 0, 1'b1);

        // Data-hold independence: 0x3C then garbage on the inputs
        send(0, 8'h3C);
        check_frame(0, frame_len(8, 4), 1, "3c");
        valid_in = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk_idle(0, "3c_no_second");
        end

        // Back-to-back 0x01 then 0x80 with valid held
        send(0, 8'h01);
        check_frame(0, frame_len(8, 4), 2, "b2b_1");
        @(negedge clk);
        chk_idle(0, "b2b_gap");
        @(posedge clk);
        push_frame(8, 4, 8'h80);
        check_frame(0, frame_len(8, 4), 3, "b2b_2");
        @(negedge clk);
        chk_idle(0, "b2b_after");

        // Reset during data bit 3 of 0x00
        send(0, 8'h00);
        check_frame(0, 18, 3, "abort");
        #2 rst_n = 1'b0;
        #1 chk_idle(0, "abort_async");
        exp_q.delete();
        @(negedge clk);
        chk_idle(0, "abort_held");
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 8'h55);
        check_frame(0, frame_len(8, 4), 3, "55");
        @(negedge clk);
        chk_idle(0, "55_after");

        // Corner instance: DATA_W=1, CLK_DIV=1, send 1
        @(negedge clk);
        chk_idle(1, "c_idle");
        send(1, 8'h01);
        check_frame(1, frame_len(1, 1), 3, "c1");
        @(negedge clk);
        chk_idle(1, "c1_after");
        send(1, 8'h00);
        check_frame(1, frame_len(1, 1), 3, "c0");
        @(negedge clk);
        chk_idle(1, "c0_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
